// File: rtl/booth_multiplier.sv
// Sequential signed 32x32 Booth multiplier: one recoding step per clock, carry-lookahead datapath.
// Define MULT_RADIX4_EN for radix-4 recoding (16 steps); the default build is radix-2 (32 steps).

// Carry-lookahead adder: ripple inside each 4-bit group, group lookahead at every 4th carry.
module cla_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);
    logic [W-2:0] g;
    logic [W-1:0] p;
    logic [W-1:0] c;

    assign g    = a[W-2:0] & b[W-2:0];
    assign p    = a ^ b;
    assign c[0] = cin;

    genvar i;
    for (i = 0; i < W - 1; i++) begin : g_carry
        if (i % 4 == 3) begin : g_look
            assign c[i+1] = g[i] | (p[i] & g[i-1]) | (p[i] & p[i-1] & g[i-2])
                          | (p[i] & p[i-1] & p[i-2] & g[i-3]) | ((&p[i -: 4]) & c[i-3]);
        end else begin : g_ripple
            assign c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum = p ^ c;
endmodule

module booth_multiplier (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] P,
    output logic        data_resultRDY,
    output logic        data_exception,
    output logic [1:0]  dbg_state
);
`ifdef MULT_RADIX4_EN
    localparam int ACC_W = 34;
    localparam int STEPS = 16;
    localparam int CNT_W = 5;
`else
    localparam int ACC_W = 33;
    localparam int STEPS = 32;
    localparam int CNT_W = 6;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        mcand;
    logic [31:0]        mplier;
    logic               mplier_prev;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [ACC_W-1:0]   m_ext;
    logic [ACC_W-1:0]   addend;
    logic               add_cin;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   acc_next;
    logic [31:0]        mplier_next;
    logic               prev_next;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ovf_next;

    assign m_ext = {{(ACC_W - 32){mcand[31]}}, mcand};

`ifdef MULT_RADIX4_EN
    // Negative digits use the one's complement of the addend plus carry-in.
    always_comb begin
        addend  = '0;
        add_cin = 1'b0;
        case ({mplier[1:0], mplier_prev})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = {m_ext[ACC_W-2:0], 1'b0};
            3'b100: begin
                addend  = ~{m_ext[ACC_W-2:0], 1'b0};
                add_cin = 1'b1;
            end
            3'b101, 3'b110: begin
                addend  = ~m_ext;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign acc_next    = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
    assign mplier_next = {sum[1:0], mplier[31:2]};
    assign prev_next   = mplier[1];
`else
    always_comb begin
        addend  = '0;
        add_cin = 1'b0;
        case ({mplier[0], mplier_prev})
            2'b01: addend = m_ext;
            2'b10: begin
                addend  = ~m_ext;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign acc_next    = {sum[ACC_W-1], sum[ACC_W-1:1]};
    assign mplier_next = {sum[0], mplier[31:1]};
    assign prev_next   = mplier[0];
`endif

    cla_adder #(.W(ACC_W)) u_acc_add (
        .a   (acc),
        .b   (addend),
        .cin (add_cin),
        .sum (sum)
    );

    cla_adder #(.W(CNT_W)) u_cnt_inc (
        .a   (cnt),
        .b   ({CNT_W{1'b0}}),
        .cin (1'b1),
        .sum (cnt_inc)
    );

    // Upper product half lives in acc_next[31:0], lower half in mplier_next after the last step.
    assign ovf_next = (acc_next[31:0] != {32{mplier_next[31]}});

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            mcand          <= '0;
            mplier         <= '0;
            mplier_prev    <= 1'b0;
            acc            <= '0;
            cnt            <= '0;
            P              <= '0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
        end else if (ctrl_MULT) begin
            state          <= RUN;
            mcand          <= A;
            mplier         <= B;
            mplier_prev    <= 1'b0;
            acc            <= '0;
            cnt            <= '0;
            P              <= '0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    acc         <= acc_next;
                    mplier      <= mplier_next;
                    mplier_prev <= prev_next;
                    cnt         <= cnt_inc;
                    if (cnt_inc == LAST) begin
                        state          <= DONE;
                        P              <= mplier_next;
                        data_resultRDY <= 1'b1;
                        data_exception <= ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;
endmodule
